mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single RAM between the CPU control path (MAR/MRW/MCS fetch+execute) and a host
//  loader/debug port. Grants one requester at a time with round-robin fairness, drives RAM
//  chip-select/read-write/address/data for a fixed number of wait cycles, and returns read data
//  with a one-cycle ack pulse. Sits between controlUnit/datapath and the RAM model.
// PARAMETERS
//  DBus         5   data width of RAM word and both requester data buses
//  ABus         5   RAM address width
//  WAIT_CYCLES  1   cycles mem_cs held active per access (>=1; RAM read latency)
// PORTS
//  clock        in   1     system clock, all state on rising edge
//  reset        in   1     synchronous, active-high
//  cpu_req      in   1     CPU access request, level, held until cpu_ack
//  cpu_we       in   1     1=write, 0=read
//  cpu_addr     in   ABus  CPU address (MAR)
//  cpu_wdata    in   DBus  CPU write data
//  cpu_rdata    out  DBus  read data, valid while cpu_ack=1 and held until next CPU read
//  cpu_ack      out  1     one-cycle completion pulse to CPU
//  host_req/host_we/host_addr/host_wdata/host_rdata/host_ack  same as cpu_* for host port
//  mem_cs       out  1     RAM chip select, active-low (0=selected)
//  mem_rw       out  1     RAM direction, 0=read, 1=write (valid only while mem_cs=0)
//  mem_addr     out  ABus  RAM address
//  mem_wdata    out  DBus  RAM write data
//  mem_rdata    in   DBus  RAM read data
//  busy         out  1     1 while state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, mem_cs=1, mem_rw=0, mem_addr=0, mem_wdata=0, cpu/host_rdata=0, acks=0,
//   busy=0, last_grant=HOST (so CPU wins first tie). Reset mid-access aborts it: no ack issued.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: if exactly one req high, grant it; if both, grant the one != last_grant. On grant edge:
//    latch addr/we/wdata into mem_* regs, mem_cs<=0, mem_rw<=we, wait counter<=WAIT_CYCLES-1,
//    last_grant<=winner, go ACCESS. No req: stay IDLE, outputs unchanged, mem_cs=1.
//   ACCESS: hold mem_* stable; decrement counter each cycle. When counter==0: capture mem_rdata
//    into winner's rdata (reads only; writes leave rdata unchanged), mem_cs<=1, mem_rw<=0,
//    winner ack<=1, go DONE.
//   DONE: ack high this cycle only; ack<=0, go IDLE. New grant earliest the following cycle.
//  Latency: req high in cycle N (IDLE) -> mem_cs low cycles N+1..N+WAIT_CYCLES -> ack in cycle
//   N+WAIT_CYCLES+1. Back-to-back accesses every WAIT_CYCLES+2 cycles.
//  Handshake: requester keeps req high until ack; must drop it in the ack cycle or it is taken
//   as a new request in the next IDLE. Address/data changes after grant are ignored (latched).
//  Req dropped during ACCESS: access still completes, ack still pulses (requester ignores it).
//  Never both acks high; never mem_cs=0 outside ACCESS. Counter width $clog2(WAIT_CYCLES+1).
//  Simultaneous: the loser's req is held off and must be granted next IDLE (no starvation:
//   at most one intervening access by the other port).
// STRUCTURE
//  Shared package mem_arb_pkg: state encodings (IDLE/ACCESS/DONE), grant IDs GNT_CPU/GNT_HOST,
//   MEM_CS_ON=0 / MEM_CS_OFF=1, MEM_READ=0 / MEM_WRITE=1 constants (also used by controlUnit).
//  One sub-module: mem_wait_counter (load, decrement, zero flag; parameter WAIT_CYCLES).
//  Arbitration, mem_* output regs and FSM live in the top module.
// TESTING
//  1 reset=1 two cycles, no req -> mem_cs=1, mem_rw=0, acks=0, rdata=0, busy=0.
//  2 WAIT_CYCLES=1, cpu_req read addr 5'd3, RAM[3]=5'h0A -> mem_cs=0 one cycle with addr 3,
//    cpu_ack in cycle N+2, cpu_rdata=5'h0A; host_ack stays 0.
//  3 host write addr 7 data 5'h15 then cpu read addr 7 -> mem_rw=1 during write, cpu_rdata=5'h15.
//  4 cpu_req and host_req high together, held 3 accesses -> grants CPU,HOST,CPU in order.
//  5 WAIT_CYCLES=3, reset asserted in 2nd ACCESS cycle -> next cycle IDLE, mem_cs=1, no ack.
//  6 cpu_addr changed 1 cycle after grant -> mem_addr keeps original value through ACCESS.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the RAM port arbiter and its users.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_HOST = 1'b1
    } grant_t;

    localparam logic MEM_CS_ON  = 1'b0;
    localparam logic MEM_CS_OFF = 1'b1;
    localparam logic MEM_READ   = 1'b0;
    localparam logic MEM_WRITE  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU port, host port and RAM-side signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int DBus = 5,
    parameter int ABus = 5
);
    logic            cpu_req;
    logic            cpu_we;
    logic [ABus-1:0] cpu_addr;
    logic [DBus-1:0] cpu_wdata;
    logic [DBus-1:0] cpu_rdata;
    logic            cpu_ack;

    logic            host_req;
    logic            host_we;
    logic [ABus-1:0] host_addr;
    logic [DBus-1:0] host_wdata;
    logic [DBus-1:0] host_rdata;
    logic            host_ack;

    logic            mem_cs;
    logic            mem_rw;
    logic [ABus-1:0] mem_addr;
    logic [DBus-1:0] mem_wdata;
    logic [DBus-1:0] mem_rdata;

    logic            busy;

    // Requesters and RAM model
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_cs, mem_rw, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

    // Arbiter
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_cs, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );
endinterface

// File: rtl/mem_wait_counter.sv
// Down-counter timing how long chip-select stays active for one access.
module mem_wait_counter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Load on grant, count down while the access is in flight, saturate at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WAIT_CYCLES - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM between the CPU and the host loader port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DBus        = 5,
    parameter int ABus        = 5,
    parameter int WAIT_CYCLES = 1
) (
    input logic                clock,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);
    arb_state_t state, state_nxt;
    grant_t     last_grant;
    grant_t     winner;
    logic       grant_any;
    logic       cnt_zero;

    // Pick a winner: single requester wins outright, a tie goes to whoever did not go last
    always_comb begin
        winner    = GNT_CPU;
        grant_any = bus.cpu_req | bus.host_req;
        if (bus.cpu_req && bus.host_req) begin
            winner = (last_grant == GNT_CPU) ? GNT_HOST : GNT_CPU;
        end else if (bus.host_req) begin
            winner = GNT_HOST;
        end
    end

    mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clock (clock),
        .reset (reset),
        .load  ((state == IDLE) && grant_any),
        .dec   (state == ACCESS),
        .zero  (cnt_zero)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ACCESS;
            ACCESS:  if (cnt_zero)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM drive, read-data capture and ack pulses; last_grant doubles as the current owner
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.mem_cs     <= MEM_CS_OFF;
            bus.mem_rw     <= MEM_READ;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.cpu_rdata  <= '0;
            bus.host_rdata <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.host_ack   <= 1'b0;
            last_grant     <= GNT_HOST;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= winner;
                        bus.mem_cs <= MEM_CS_ON;
                        if (winner == GNT_CPU) begin
                            bus.mem_rw    <= bus.cpu_we;
                            bus.mem_addr  <= bus.cpu_addr;
                            bus.mem_wdata <= bus.cpu_wdata;
                        end else begin
                            bus.mem_rw    <= bus.host_we;
                            bus.mem_addr  <= bus.host_addr;
                            bus.mem_wdata <= bus.host_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        bus.mem_cs <= MEM_CS_OFF;
                        bus.mem_rw <= MEM_READ;
                        if (last_grant == GNT_CPU) begin
                            bus.cpu_ack <= 1'b1;
                            if (bus.mem_rw == MEM_READ) bus.cpu_rdata <= bus.mem_rdata;
                        end else begin
                            bus.host_ack <= 1'b1;
                            if (bus.mem_rw == MEM_READ) bus.host_rdata <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    bus.cpu_ack  <= 1'b0;
                    bus.host_ack <= 1'b0;
                end
                default: begin
                    bus.cpu_ack  <= 1'b0;
                    bus.host_ack <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
endmodule
